// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet TX framing constants and framer state type
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 7;
  localparam logic [10:0] MAX_FRAME_LEN = 11'd1514;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    DRAIN,
    IFG
  } tx_state_e;

endpackage

// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - Ethernet TX framer: preamble/SFD, payload from FIFO, pad, IFG
// Reads run two cycles ahead of txd; an underrun stops reading until the frame is drained.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int IFG_CYC = 12
) (
  input  logic        rclk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [10:0] tx_len,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rdata,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_err
);

  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
  localparam logic [10:0] IFG_LAST  = 11'(IFG_CYC - 1);
  localparam logic [10:0] PRE_LAST  = 11'(PREAMBLE_LEN - 1);

  tx_state_e   state_q, state_d;
  logic [10:0] len_q, len_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] rd_cnt_q, rd_cnt_d;
  logic [10:0] tx_cnt_q, tx_cnt_d;
  logic        ur_q, ur_d;
  logic        rd_p1_q;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        busy_q;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rd_due;
  logic        rd_en;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    rd_cnt_d = rd_cnt_q;
    tx_cnt_d = tx_cnt_q;
    ur_d     = ur_q;
    txd_d    = 8'h00;
    tx_en_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rd_due   = 1'b0;
    rd_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          if (tx_len != 11'd0 && tx_len <= MAX_FRAME_LEN) begin
            state_d  = PRE;
            len_d    = tx_len;
            cnt_d    = 11'd0;
            rd_cnt_d = 11'd0;
            tx_cnt_d = 11'd0;
            ur_d     = 1'b0;
            txd_d    = PREAMBLE_BYTE;
            tx_en_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PRE: begin
        tx_en_d = 1'b1;
        rd_due  = (cnt_q == PRE_LAST);
        if (cnt_q == PRE_LAST) begin
          state_d = SFD;
          txd_d   = SFD_BYTE;
        end else begin
          txd_d = PREAMBLE_BYTE;
          cnt_d = cnt_q + 11'd1;
        end
      end
      SFD, DATA: begin
        rd_due = 1'b1;
        // A read last cycle means a payload byte is on fifo_rdata now.
        if (rd_p1_q) begin
          state_d  = DATA;
          txd_d    = fifo_rdata;
          tx_en_d  = 1'b1;
          tx_cnt_d = tx_cnt_q + 11'd1;
        end else if (ur_q) begin
          state_d = DRAIN;
          err_d   = 1'b1;
        end else if (tx_cnt_q < MIN_LEN_C) begin
          state_d  = PAD;
          tx_en_d  = 1'b1;
          tx_cnt_d = tx_cnt_q + 11'd1;
        end else begin
          state_d = IFG;
          cnt_d   = 11'd0;
          done_d  = 1'b1;
        end
      end
      PAD: begin
        if (tx_cnt_q < MIN_LEN_C) begin
          tx_en_d  = 1'b1;
          tx_cnt_d = tx_cnt_q + 11'd1;
        end else begin
          state_d = IFG;
          cnt_d   = 11'd0;
          done_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (rd_cnt_q == len_q) begin
          state_d = IFG;
          cnt_d   = 11'd0;
        end else if (!fifo_empty) begin
          rd_en = 1'b1;
        end
      end
      IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Once an underrun is seen no further reads are issued until DRAIN.
    if (rd_due && !ur_q && rd_cnt_q != len_q) begin
      if (fifo_empty) begin
        ur_d = 1'b1;
      end else begin
        rd_en = 1'b1;
      end
    end
    if (rd_en) begin
      rd_cnt_d = rd_cnt_q + 11'd1;
    end
    fifo_rd_en = rd_en && !rst;
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= 11'd0;
      cnt_q    <= 11'd0;
      rd_cnt_q <= 11'd0;
      tx_cnt_q <= 11'd0;
      ur_q     <= 1'b0;
      rd_p1_q  <= 1'b0;
      txd_q    <= 8'h00;
      tx_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      ur_q     <= ur_d;
      rd_p1_q  <= rd_en;
      txd_q    <= txd_d;
      tx_en_q  <= tx_en_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign txd     = txd_q;
  assign tx_en   = tx_en_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign tx_err  = err_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - directed self-checking bench for eth_tx_framer
module tb_eth_tx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 1'b0;
  logic [10:0] tx_len = 11'd0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rdata = 8'h00;
  logic [7:0]  txd;
  logic        tx_en, tx_busy, tx_done, tx_err;

  int checks = 0;
  int errors = 0;
  int gcyc = 0;
  int t0 = 0;
  int base = 0;
  int rd_idx = 0;
  int empty_at = -1;

  logic       en_a[256];
  logic       rd_a[256];
  logic       done_a[256];
  logic       err_a[256];
  logic       busy_a[256];
  logic [7:0] d_a[256];

  always #5 clk = ~clk;

  eth_tx_framer #(.MIN_LEN(60), .IFG_CYC(12)) dut (
    .rclk      (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .tx_len    (tx_len),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata),
    .txd       (txd),
    .tx_en     (tx_en),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  assign fifo_empty = ((gcyc - t0) == empty_at);

  always @(posedge clk) begin
    gcyc <= gcyc + 1;
    if (fifo_rd_en) begin
      fifo_rdata <= pat(rd_idx);
      rd_idx     <= rd_idx + 1;
    end
  end

  always @(negedge clk) begin
    int rel;
    rel = gcyc - t0;
    if (rel >= 0 && rel < 256) begin
      en_a[rel]   = tx_en;
      rd_a[rel]   = fifo_rd_en;
      done_a[rel] = tx_done;
      err_a[rel]  = tx_err;
      busy_a[rel] = tx_busy;
      d_a[rel]    = txd;
    end
  end

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic wait_to(input int c);
    while (gcyc - t0 < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic [10:0] len);
    t0       = gcyc;
    base     = rd_idx;
    tx_start = 1'b1;
    tx_len   = len;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " txd"}, 0, txd, 8'h00);
    chk({tag, " tx_en"}, 0, tx_en, 1'b0);
    chk({tag, " rd_en"}, 0, fifo_rd_en, 1'b0);
    chk({tag, " busy"}, 0, tx_busy, 1'b0);
    chk({tag, " done"}, 0, tx_done, 1'b0);
    chk({tag, " err"}, 0, tx_err, 1'b0);
  endtask

  task automatic run_normal(input string tag, input int len, input bit pulses);
    int pad, last, done_c, idle_c;
    logic [7:0] exp_d;
    pad    = (len < 60) ? 60 : len;
    last   = 8 + pad;
    done_c = last + 1;
    idle_c = done_c + 12;
    start_frame(11'(len));
    if (pulses) begin
      wait_to(20);
      tx_start = 1'b1;
      tx_len   = 11'd0;
      @(posedge clk);
      #1;
      tx_start = 1'b0;
      wait_to(done_c + 5);
      tx_start = 1'b1;
      tx_len   = 11'd5;
      @(posedge clk);
      #1;
      tx_start = 1'b0;
    end
    wait_to(idle_c + 6);
    for (int c = 0; c <= idle_c + 4; c++) begin
      chk({tag, " tx_en"}, c, en_a[c], (c >= 1 && c <= last));
      chk({tag, " rd_en"}, c, rd_a[c], (c >= 7 && c < 7 + len));
      chk({tag, " tx_done"}, c, done_a[c], (c == done_c));
      chk({tag, " tx_err"}, c, err_a[c], 1'b0);
      chk({tag, " tx_busy"}, c, busy_a[c], (c >= 1 && c < idle_c));
      if (c >= 1 && c <= last) begin
        if (c <= 7)            exp_d = 8'h55;
        else if (c == 8)       exp_d = 8'hD5;
        else if (c < 9 + len)  exp_d = pat(base + c - 9);
        else                   exp_d = 8'h00;
        chk({tag, " txd"}, c, d_a[c], exp_d);
      end
    end
    chk({tag, " reads"}, 0, rd_idx - base, len);
  endtask

  task automatic run_bad_len(input string tag, input logic [10:0] len);
    int n_err, n_busy, n_en;
    start_frame(len);
    wait_to(8);
    n_err = 0; n_busy = 0; n_en = 0;
    for (int c = 0; c < 8; c++) begin
      n_err  += int'(err_a[c]);
      n_busy += int'(busy_a[c]);
      n_en   += int'(en_a[c]);
    end
    chk({tag, " err pulse"}, 1, err_a[1], 1'b1);
    chk({tag, " err count"}, 0, n_err, 1);
    chk({tag, " busy count"}, 0, n_busy, 0);
    chk({tag, " en count"}, 0, n_en, 0);
    chk({tag, " reads"}, 0, rd_idx - base, 0);
  endtask

  initial begin
    int n_en, n_err, n_done;

    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;

    run_normal("len64", 64, 1'b0);
    run_normal("len10", 10, 1'b0);
    run_normal("ignored start", 64, 1'b1);

    start_frame(11'd100);
    empty_at = 27;
    wait_to(200);
    empty_at = -1;
    n_en = 0; n_err = 0; n_done = 0;
    for (int c = 0; c < 200; c++) begin
      n_en   += int'(en_a[c]);
      n_err  += int'(err_a[c]);
      n_done += int'(done_a[c]);
    end
    for (int c = 9; c <= 28; c++) begin
      chk("underrun txd", c, d_a[c], pat(base + c - 9));
    end
    chk("underrun en 28", 28, en_a[28], 1'b1);
    chk("underrun en 29", 29, en_a[29], 1'b0);
    chk("underrun en count", 0, n_en, 28);
    chk("underrun err 29", 29, err_a[29], 1'b1);
    chk("underrun err count", 0, n_err, 1);
    chk("underrun done count", 0, n_done, 0);
    chk("underrun rd 26", 26, rd_a[26], 1'b1);
    chk("underrun rd 27", 27, rd_a[27], 1'b0);
    chk("underrun reads", 0, rd_idx - base, 100);
    chk("underrun busy 29", 29, busy_a[29], 1'b1);
    chk("underrun busy end", 199, busy_a[199], 1'b0);

    run_bad_len("len0", 11'd0);
    run_bad_len("len1515", 11'd1515);

    start_frame(11'd64);
    wait_to(30);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle_outputs("mid-frame rst");
    run_normal("after rst", 64, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
